// File: rtl/ecall_ctrl_pkg.sv
// Shared definitions for the environment-call sequencer: FSM states and the
// syscall codes that the decoder and the bench also use.
package ecall_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    WAIT_CONF,
    WAIT_IN,
    WRITEBACK,
    RELEASE,
    HALT
  } state_t;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_READ_INT  = 32'd5;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  // States that keep fetch frozen regardless of the ecall flag.
  function automatic logic holds_pipeline(input state_t s);
    return (s == DISPATCH) || (s == WAIT_CONF) || (s == WAIT_IN) ||
           (s == WRITEBACK) || (s == HALT);
  endfunction

endpackage

// File: rtl/ecall_ctrl_rise_edge.sv
// Rising-edge detector for a debounced button level: keeps the previous level
// and flags a fresh 0->1 transition in the current cycle.
module ecall_ctrl_rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (rst) r_level_q <= 1'b0;
    else     r_level_q <= i_level;
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/ecall_ctrl.sv
// Environment-call sequencer: freezes fetch on an ecall and performs the
// print / read-switches / exit action selected by a7.
module ecall_ctrl
  import ecall_ctrl_pkg::*;
#(
  parameter int SW_W       = 16,
  parameter int PRINT_WAIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall,
  input  logic [31:0]     a7,
  input  logic [31:0]     a0,
  input  logic [SW_W-1:0] sw_in,
  input  logic            confirm,
  output logic            stall,
  output logic            wb_en,
  output logic [31:0]     wb_data,
  output logic            io_out_valid,
  output logic [31:0]     io_out_data,
  output logic            halted
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a7;
  logic [31:0] r_a0;
  logic [31:0] r_wb_data;
  logic [31:0] r_io_data;
  logic        r_io_valid;
  logic        w_cfg_edge;
  logic        w_accept;
  logic        w_print_go;
  logic        w_sw_take;
  logic [31:0] w_sw_ext;

  ecall_ctrl_rise_edge u_confirm_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (confirm),
    .o_rise  (w_cfg_edge)
  );

  assign w_accept   = (r_state == IDLE) && ecall;
  assign w_print_go = (r_state == DISPATCH) && (r_a7 == SYS_PRINT_INT);
  assign w_sw_take  = (r_state == WAIT_IN) && w_cfg_edge;
  assign w_sw_ext   = 32'(sw_in);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Syscall operands are only meaningful once accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a7 <= a7;
      r_a0 <= a0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_io_valid <= 1'b0;
      r_io_data  <= 32'd0;
      r_wb_data  <= 32'd0;
    end else begin
      r_io_valid <= w_print_go;
      if (w_print_go) r_io_data <= r_a0;
      if (w_sw_take)  r_wb_data <= w_sw_ext;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (ecall) w_next = DISPATCH;
      end
      DISPATCH: begin
        case (r_a7)
          SYS_PRINT_INT: w_next = (PRINT_WAIT != 0) ? WAIT_CONF : RELEASE;
          SYS_READ_INT:  w_next = WAIT_IN;
          SYS_EXIT:      w_next = HALT;
          default:       w_next = RELEASE;
        endcase
      end
      WAIT_CONF: begin
        if (w_cfg_edge) w_next = RELEASE;
      end
      WAIT_IN: begin
        if (w_cfg_edge) w_next = WRITEBACK;
      end
      WRITEBACK: w_next = RELEASE;
      // One unstalled cycle lets the ecall retire; ecall is not looked at here.
      RELEASE:   w_next = IDLE;
      HALT:      w_next = HALT;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    wb_en  = 1'b0;
    halted = 1'b0;
    stall  = ((r_state == IDLE) && ecall) || holds_pipeline(r_state);
    wb_en  = (r_state == WRITEBACK);
    halted = (r_state == HALT);
  end

  assign wb_data      = r_wb_data;
  assign io_out_valid = r_io_valid;
  assign io_out_data  = r_io_data;

endmodule

// File: tb/tb_ecall_ctrl.sv
// Bench for ecall_ctrl: timeline-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ecall_ctrl;
  import ecall_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ecall, ecall0, confirm;
  logic [31:0] a7, a0;
  logic [15:0] sw_in;
  logic        stall, wb_en, io_out_valid, halted;
  logic [31:0] wb_data, io_out_data;
  logic        stall0, wb_en0, io_out_valid0, halted0;
  logic [31:0] wb_data0, io_out_data0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ecall_ctrl #(.SW_W(16), .PRINT_WAIT(1)) dut (
    .clk(clk), .rst(rst), .ecall(ecall), .a7(a7), .a0(a0), .sw_in(sw_in),
    .confirm(confirm), .stall(stall), .wb_en(wb_en), .wb_data(wb_data),
    .io_out_valid(io_out_valid), .io_out_data(io_out_data), .halted(halted)
  );

  ecall_ctrl #(.SW_W(16), .PRINT_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .ecall(ecall0), .a7(a7), .a0(a0), .sw_in(sw_in),
    .confirm(confirm), .stall(stall0), .wb_en(wb_en0), .wb_data(wb_data0),
    .io_out_valid(io_out_valid0), .io_out_data(io_out_data0), .halted(halted0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted call is tracked by its age (1 = the cycle
  // after acceptance) and the age at which the confirm press was seen.
  bit          m_active;
  int          m_age, m_press;
  logic [31:0] m_code, m_arg, m_wb, m_io;
  logic        m_prev;

  function automatic bit m_waits();
    return (m_code == SYS_PRINT_INT) || (m_code == SYS_READ_INT);
  endfunction

  function automatic bit m_releasing();
    if (m_code == SYS_PRINT_INT) return (m_press >= 0) && (m_age == m_press + 1);
    if (m_code == SYS_READ_INT)  return (m_press >= 0) && (m_age == m_press + 2);
    if (m_code == SYS_EXIT)      return 1'b0;
    return m_age == 2;
  endfunction

  always @(posedge clk) begin
    m_prev <= rst ? 1'b0 : confirm;
    if (rst) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_press  <= -1;
      m_wb     <= 32'd0;
      m_io     <= 32'd0;
    end else if (!m_active) begin
      if (ecall) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_code   <= a7;
        m_arg    <= a0;
        m_press  <= -1;
      end
    end else begin
      if (m_waits() && m_age >= 2 && m_press < 0 && confirm && !m_prev) begin
        m_press <= m_age;
        if (m_code == SYS_READ_INT) m_wb <= {16'd0, sw_in};
      end
      if (m_code == SYS_PRINT_INT && m_age == 1) m_io <= m_arg;
      if (m_releasing()) m_active <= 1'b0;
      else if (m_age < 100000) m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",   {31'd0, stall},
          {31'd0, m_active ? !m_releasing() : ecall});
      chk("halted",  {31'd0, halted},
          {31'd0, m_active && m_code == SYS_EXIT && m_age >= 2});
      chk("wb_en",   {31'd0, wb_en},
          {31'd0, m_active && m_code == SYS_READ_INT && m_press >= 0 && m_age == m_press + 1});
      chk("io_valid", {31'd0, io_out_valid},
          {31'd0, m_active && m_code == SYS_PRINT_INT && m_age == 2});
      chk("wb_data", wb_data, m_wb);
      chk("io_data", io_out_data, m_io);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; ecall = 1'b1; ecall0 = 1'b0; confirm = 1'b0;
    a7 = 32'd0; a0 = 32'd0; sw_in = 16'd0;

    // Reset held two cycles with ecall high
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    rst = 1'b0; ecall = 1'b0;
    @(negedge clk);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst halted", {31'd0, halted}, 32'd0);
    chk("rst io_data", io_out_data, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst0 stall", {31'd0, stall0}, 32'd0);
    cyc(1); confirm = 1'b1;
    cyc(1); confirm = 1'b0;
    cyc(1);

    // Print with confirm wait, ecall held through the release cycle
    a7 = 32'd1; a0 = 32'hDEADBEEF; ecall = 1'b1;
    @(negedge clk);
    chk("print accept stall", {31'd0, stall}, 32'd1);
    cyc(2);
    @(negedge clk);
    chk("print io_valid", {31'd0, io_out_valid}, 32'd1);
    chk("print io_data", io_out_data, 32'hDEADBEEF);
    chk("model io", m_io, 32'hDEADBEEF);
    cyc(3);
    @(negedge clk);
    chk("print wait stall", {31'd0, stall}, 32'd1);
    chk("print single pulse", {31'd0, io_out_valid}, 32'd0);
    confirm = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("print release stall", {31'd0, stall}, 32'd0);
    cyc(1); ecall = 1'b0; confirm = 1'b0;
    @(negedge clk);
    chk("print no retrigger", {31'd0, stall}, 32'd0);
    cyc(2);

    // Read with confirm already high before the call
    confirm = 1'b1;
    cyc(2);
    a7 = 32'd5; sw_in = 16'h00A5; ecall = 1'b1;
    cyc(2);
    cyc(3);
    @(negedge clk);
    chk("read held level", {31'd0, wb_en}, 32'd0);
    chk("read wait stall", {31'd0, stall}, 32'd1);
    confirm = 1'b0;
    cyc(2);
    confirm = 1'b1;
    cyc(1);
    sw_in = 16'hFFFF; confirm = 1'b0;
    @(negedge clk);
    chk("read wb_en", {31'd0, wb_en}, 32'd1);
    chk("read wb_data", wb_data, 32'h000000A5);
    chk("model wb", m_wb, 32'h000000A5);
    cyc(1);
    @(negedge clk);
    chk("read release stall", {31'd0, stall}, 32'd0);
    chk("read wb_en once", {31'd0, wb_en}, 32'd0);
    cyc(1); ecall = 1'b0;
    cyc(2);

    // Read with press in the first waiting cycle
    a7 = 32'd5; sw_in = 16'h8001; ecall = 1'b1;
    cyc(2); confirm = 1'b1;
    cyc(1); confirm = 1'b0;
    @(negedge clk);
    chk("read2 wb_data", wb_data, 32'h00008001);
    cyc(1);
    cyc(1); ecall = 1'b0;
    cyc(1);

    // Second print, pressed immediately; io_data held through the reads
    a7 = 32'd1; a0 = 32'h00000001; ecall = 1'b1;
    cyc(2); confirm = 1'b1;
    @(negedge clk);
    chk("print2 io_data", io_out_data, 32'h00000001);
    cyc(1); confirm = 1'b0;
    @(negedge clk);
    chk("print2 release", {31'd0, stall}, 32'd0);
    cyc(1); ecall = 1'b0;
    cyc(1);

    // Unknown codes: two stall cycles then release
    a7 = 32'd7; ecall = 1'b1;
    @(negedge clk);
    chk("unk stall c0", {31'd0, stall}, 32'd1);
    cyc(1);
    @(negedge clk);
    chk("unk stall c1", {31'd0, stall}, 32'd1);
    cyc(1);
    @(negedge clk);
    chk("unk release", {31'd0, stall}, 32'd0);
    chk("unk no wb", {31'd0, wb_en}, 32'd0);
    chk("unk no io", {31'd0, io_out_valid}, 32'd0);
    cyc(1); ecall = 1'b0;
    cyc(1);
    a7 = 32'h00000101; ecall = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("unk 0x101 release", {31'd0, stall}, 32'd0);
    cyc(1); ecall = 1'b0;
    cyc(1);

    // Print with PRINT_WAIT=0 on the second instance
    a7 = 32'd1; a0 = 32'h12345678; ecall0 = 1'b1;
    @(negedge clk);
    chk("pw0 accept", {31'd0, stall0}, 32'd1);
    cyc(1);
    @(negedge clk);
    chk("pw0 dispatch", {31'd0, stall0}, 32'd1);
    chk("pw0 no io yet", {31'd0, io_out_valid0}, 32'd0);
    cyc(1);
    @(negedge clk);
    chk("pw0 release", {31'd0, stall0}, 32'd0);
    chk("pw0 io_valid", {31'd0, io_out_valid0}, 32'd1);
    chk("pw0 io_data", io_out_data0, 32'h12345678);
    cyc(1); ecall0 = 1'b0;
    @(negedge clk);
    chk("pw0 idle", {31'd0, stall0}, 32'd0);
    chk("pw0 pulse once", {31'd0, io_out_valid0}, 32'd0);
    cyc(1);

    // Exit: halted survives confirm pulses and ecall activity
    a7 = 32'd10; ecall = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("exit halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 110; i++) begin
      confirm = ((i % 6) < 3);
      ecall   = ((i % 2) == 0);
      cyc(1);
    end
    @(negedge clk);
    chk("exit still halted", {31'd0, halted}, 32'd1);
    chk("exit still stall", {31'd0, stall}, 32'd1);
    rst = 1'b1; confirm = 1'b0;
    cyc(1);
    rst = 1'b0; ecall = 1'b0;
    @(negedge clk);
    chk("exit rst halted", {31'd0, halted}, 32'd0);
    chk("exit rst stall", {31'd0, stall}, 32'd0);
    cyc(2);

    // Reset while waiting for the switch read
    a7 = 32'd5; sw_in = 16'h0033; ecall = 1'b1;
    cyc(4);
    rst = 1'b1; confirm = 1'b1; ecall = 1'b0;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst stall", {31'd0, stall}, 32'd0);
    chk("midrst wb_en", {31'd0, wb_en}, 32'd0);
    chk("midrst wb_data", wb_data, 32'd0);
    cyc(3); confirm = 1'b0;
    cyc(2); confirm = 1'b1;
    cyc(2); confirm = 1'b0;
    cyc(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
